// File: rtl/skew_feed_pkg.sv
// Shared types and sizing helpers for the skewed activation feed controller.
package skew_feed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int N_DEFAULT = 4;

    function automatic int shift_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_feed_ctrl_if.sv
// Tile handshake, shift-buffer/PE control and result handshake bundle.
// master = tile source / result sink side, slave = the controller.
interface skew_feed_ctrl_if;
    logic tile_valid;
    logic tile_last;
    logic tile_ready;
    logic buf_load;
    logic buf_shift;
    logic pe_clear;
    logic pe_en;
    logic result_valid;
    logic result_ready;
    logic busy;

    modport master (
        output tile_valid, tile_last, result_ready,
        input  tile_ready, buf_load, buf_shift, pe_clear, pe_en, result_valid, busy
    );

    modport slave (
        input  tile_valid, tile_last, result_ready,
        output tile_ready, buf_load, buf_shift, pe_clear, pe_en, result_valid, busy
    );
endinterface

// File: rtl/skew_feed_ctrl_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/skew_feed_ctrl.sv
// Sequencer for the skewed activation shift buffer and N x N PE array.
// Optional counters perf_tiles/perf_stall are built when SKEW_FEED_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a tile, tile_ready high
// LOAD  | one-cycle buffer parallel load, PE clear on first tile of a matrix
// SHIFT | 2N-1 cycles of skewed shift with PE accumulation
// DRAIN | N cycles shifting zeros to flush the array after the last tile
// DONE  | result_valid held until result_ready is sampled
module skew_feed_ctrl
    import skew_feed_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             reset,
    skew_feed_ctrl_if.slave  bus
`ifdef SKEW_FEED_PERF_EN
    ,
    output logic [15:0]      perf_tiles,
    output logic [15:0]      perf_stall
`endif
);

    localparam int SHIFT_LEN = shift_len(N);
    localparam int DRAIN_LEN = N;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          first_tile;
    logic          last_q;

    logic tile_ready_q;
    logic buf_load_q;
    logic buf_shift_q;
    logic pe_clear_q;
    logic pe_en_q;
    logic result_valid_q;
    logic busy_q;

    logic handshake;

    assign handshake = (state == IDLE) && bus.tile_valid && tile_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            first_tile     <= 1'b1;
            last_q         <= 1'b0;
            tile_ready_q   <= 1'b0;
            buf_load_q     <= 1'b0;
            buf_shift_q    <= 1'b0;
            pe_clear_q     <= 1'b0;
            pe_en_q        <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // Strobes default low; each branch raises what the next state needs.
            buf_load_q  <= 1'b0;
            buf_shift_q <= 1'b0;
            pe_clear_q  <= 1'b0;
            pe_en_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        last_q       <= bus.tile_last;
                        state        <= LOAD;
                        tile_ready_q <= 1'b0;
                        buf_load_q   <= 1'b1;
                        pe_clear_q   <= first_tile;
                        busy_q       <= 1'b1;
                    end else begin
                        tile_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                LOAD: begin
                    first_tile  <= 1'b0;
                    cnt         <= '0;
                    state       <= SHIFT;
                    buf_shift_q <= 1'b1;
                    pe_en_q     <= 1'b1;
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt <= '0;
                        if (last_q) begin
                            state       <= DRAIN;
                            buf_shift_q <= 1'b1;
                            pe_en_q     <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            tile_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end
                    end else begin
                        cnt         <= cnt + CW'(1);
                        buf_shift_q <= 1'b1;
                        pe_en_q     <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        cnt            <= '0;
                        state          <= DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        cnt         <= cnt + CW'(1);
                        buf_shift_q <= 1'b1;
                        pe_en_q     <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state          <= IDLE;
                        result_valid_q <= 1'b0;
                        tile_ready_q   <= 1'b1;
                        busy_q         <= 1'b0;
                        first_tile     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tile_ready   = tile_ready_q;
    assign bus.buf_load     = buf_load_q;
    assign bus.buf_shift    = buf_shift_q;
    assign bus.pe_clear     = pe_clear_q;
    assign bus.pe_en        = pe_en_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;

`ifdef SKEW_FEED_PERF_EN
    sat_counter #(.W(16)) u_perf_tiles (
        .clk   (clk),
        .reset (reset),
        .inc   (handshake),
        .count (perf_tiles)
    );

    sat_counter #(.W(16)) u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .inc   ((state == DONE) && !bus.result_ready),
        .count (perf_stall)
    );
`endif

endmodule
